dpram_access_arbiter: RTL and testbench
=======================================

# dpram_access_arbiter

Initiator-side front end for the 16x8 dual-port RAM: it accepts read/write requests from two independent clients over valid/ready handshakes and drives both RAM ports from a registered issue stage. It also returns read data with a fixed-latency response strobe. It resolves same-cycle address conflicts with a toggling priority bit so neither client starves. It sits between the two client engines and the RAM, and is the only block that drives RAM port signals.

## Interface
- AW, 4, address width (RAM depth 2**AW)
- DW, 8, data width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid1 / req_valid2  in  1  client request valid
- req_ready1 / req_ready2  out  1  request accepted this cycle when valid&ready
- req_wr1 / req_wr2  in  1  1 = write, 0 = read
- req_addr1 / req_addr2  in  AW  request address
- req_wdata1 / req_wdata2  in  DW  write data
- rsp_valid1 / rsp_valid2  out  1  read data valid, one-cycle pulse, no backpressure
- rsp_rdata1 / rsp_rdata2  out  DW  read data, driven from ram_dout
- ram_wr1 / ram_wr2  out  1  RAM port write enable
- ram_addr1 / ram_addr2  out  AW  RAM port address
- ram_din1 / ram_din2  out  DW  RAM port write data
- ram_dout1 / ram_dout2  in  DW  RAM port registered read data
- conflict_cnt  out  8  saturating conflict count; present only with DPRAM_ARB_STATS_EN

## Operation
- Conflict: both req_valid high, req_addr1 == req_addr2, and at least one req_wr high. Read/read to the same address is not a conflict.
- No conflict: req_readyN = 1 whenever rst = 0. Both ports accept independently.
- Conflict with pri = 0: port 1 wins and req_ready2 = 0.
- Conflict with pri = 1: port 2 wins and req_ready1 = 0.
- pri toggles at the clock edge of every cycle in which a conflict occurs. Otherwise it holds.
- req_ready is combinational from the current valid/addr/wr inputs and pri.
- A loser must hold its request. It wins the following cycle if the conflict persists.
- Accepted request on port N: ram_wrN, ram_addrN and ram_dinN are registered for exactly one cycle.
- Idle port: ram_wrN = 0, ram_addrN holds its last value, ram_dinN holds.
- Accepted read: a response flag is pipelined, and rsp_validN pulses two cycles after acceptance.
- Accepted write produces no response.
- Per-port ordering is preserved. A read accepted after a write (any port, same address) returns the new data, because issue order equals acceptance order.
- Reset values: req_ready* = 0 during rst; ram_wr* = 0; ram_addr* = 0; ram_din* = 0; rsp_valid* = 0; pri = 0; conflict_cnt = 0.
- Reset mid-operation drops in-flight requests: no rsp_valid is produced for them. RAM contents are not touched.

## Timing
- Cycle T: valid&ready handshake.
- T+1: ram_* signals reflect the request. The RAM writes or latches read data at the end of T+1.
- T+2: rsp_validN = 1 and rsp_rdataN = ram_doutN.
- Throughput: one request per port per cycle when there is no conflict.
- Worst-case stall is 1 cycle per conflict, guaranteed by the pri toggle.

## Configuration
- DPRAM_ARB_STATS_EN defined:
  - conflict_cnt port exists.
  - It increments by 1 on each conflict cycle and saturates at 255.
  - It clears on rst.
- DPRAM_ARB_STATS_EN undefined: port and counter are absent. Arbitration behaviour is identical.

## Structure
- Package dpram_pkg holds:
  - AW and DW defaults
  - DEPTH = 2**AW
  - port-index typedef (PORT1/PORT2)
  - request struct typedef {wr, addr, wdata}
- Sub-module dpram_issue_port is instantiated twice. It contains the registered issue stage (ram_wr/addr/din) and the 2-deep read-response flag pipeline.
- The top level contains conflict detection, the pri register and the optional counter.

## Test plan
- Reset: hold rst 3 cycles with both valids high -> all outputs 0, no ram_wr, no rsp_valid. Release -> ready1 = ready2 = 1.
- Write then read on the same port: port 1 writes 0xA5 @3 at T, reads @3 at T+1 -> ram_wr1 at T+1, rsp_valid1 at T+3 with rdata 0xA5.
- Write/write conflict: both write @7 (0x11 / 0x22) for two cycles from pri = 0.
  - Cycle 1: port 1 accepted, ready2 = 0.
  - Cycle 2: port 2 accepted.
  - Final read @7 returns 0x22; pri ends at 0.
- Read/read same address @5: both accepted the same cycle, no stall, both rsp_valid two cycles later with equal data, pri unchanged.
- Read/write conflict @9 with pri = 1: port 2 write wins, port 1 read accepted next cycle and returns the new data.
- Stats build: 300 consecutive conflict cycles -> conflict_cnt = 255. Assert rst -> 0.

Source files
------------

// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared widths, port index and request type for the dual-port RAM arbiter
package dpram_pkg;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    PORT1 = 1'b0,
    PORT2 = 1'b1
  } port_e;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dpram_access_arbiter_if.sv
// rtl/dpram_access_arbiter_if.sv - client request/response and RAM port bundle
// master: clients plus RAM model; slave: the arbiter.
interface dpram_access_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);

  logic          req_valid1, req_valid2;
  logic          req_ready1, req_ready2;
  logic          req_wr1, req_wr2;
  logic [AW-1:0] req_addr1, req_addr2;
  logic [DW-1:0] req_wdata1, req_wdata2;
  logic          rsp_valid1, rsp_valid2;
  logic [DW-1:0] rsp_rdata1, rsp_rdata2;
  logic          ram_wr1, ram_wr2;
  logic [AW-1:0] ram_addr1, ram_addr2;
  logic [DW-1:0] ram_din1, ram_din2;
  logic [DW-1:0] ram_dout1, ram_dout2;

  modport master (
    output req_valid1, req_valid2, req_wr1, req_wr2,
    output req_addr1, req_addr2, req_wdata1, req_wdata2,
    output ram_dout1, ram_dout2,
    input  req_ready1, req_ready2, rsp_valid1, rsp_valid2,
    input  rsp_rdata1, rsp_rdata2,
    input  ram_wr1, ram_wr2, ram_addr1, ram_addr2, ram_din1, ram_din2
  );

  modport slave (
    input  req_valid1, req_valid2, req_wr1, req_wr2,
    input  req_addr1, req_addr2, req_wdata1, req_wdata2,
    input  ram_dout1, ram_dout2,
    output req_ready1, req_ready2, rsp_valid1, rsp_valid2,
    output rsp_rdata1, rsp_rdata2,
    output ram_wr1, ram_wr2, ram_addr1, ram_addr2, ram_din1, ram_din2
  );

endinterface

// File: rtl/dpram_issue_port.sv
// rtl/dpram_issue_port.sv - registered RAM issue stage and 2-deep read-response flag pipeline
module dpram_issue_port #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          rsp_valid
);

  logic rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rd_q      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      ram_wr <= accept & wr;
      if (accept) begin
        ram_addr <= addr;
        ram_din  <= wdata;
      end
      // rsp_valid lines up with the RAM's registered read data one cycle after issue
      rd_q      <= accept & ~wr;
      rsp_valid <= rd_q;
    end
  end

endmodule

// File: rtl/dpram_access_arbiter.sv
// rtl/dpram_access_arbiter.sv - two-client front end for the dual-port RAM with toggling conflict priority
// Optional saturating conflict counter behind DPRAM_ARB_STATS_EN.
module dpram_access_arbiter
  import dpram_pkg::*;
#(
  parameter int AW = dpram_pkg::AW,
  parameter int DW = dpram_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst,
  dpram_access_arbiter_if.slave  bus
`ifdef DPRAM_ARB_STATS_EN
  ,
  output logic [7:0]             conflict_cnt
`endif
);

  logic  pri;
  logic  conflict;
  port_e winner;
  logic  ready1, ready2;
  logic  accept1, accept2;

  logic          ram_wr1, ram_wr2;
  logic [AW-1:0] ram_addr1, ram_addr2;
  logic [DW-1:0] ram_din1, ram_din2;
  logic          rsp_valid1, rsp_valid2;

  // read/read to one address is harmless; any write in the pair needs ordering
  assign conflict = bus.req_valid1 & bus.req_valid2 &
                    (bus.req_addr1 == bus.req_addr2) &
                    (bus.req_wr1 | bus.req_wr2);
  assign winner   = pri ? PORT2 : PORT1;

  assign ready1  = ~rst & ~(conflict & (winner == PORT2));
  assign ready2  = ~rst & ~(conflict & (winner == PORT1));
  assign accept1 = bus.req_valid1 & ready1;
  assign accept2 = bus.req_valid2 & ready2;

  always_ff @(posedge clk) begin
    if (rst) begin
      pri <= 1'b0;
    end else if (conflict) begin
      pri <= ~pri;
    end
  end

`ifdef DPRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 8'd0;
    end else if (conflict && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

  dpram_issue_port #(.AW(AW), .DW(DW)) u_port1 (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept1),
    .wr        (bus.req_wr1),
    .addr      (bus.req_addr1),
    .wdata     (bus.req_wdata1),
    .ram_wr    (ram_wr1),
    .ram_addr  (ram_addr1),
    .ram_din   (ram_din1),
    .rsp_valid (rsp_valid1)
  );

  dpram_issue_port #(.AW(AW), .DW(DW)) u_port2 (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept2),
    .wr        (bus.req_wr2),
    .addr      (bus.req_addr2),
    .wdata     (bus.req_wdata2),
    .ram_wr    (ram_wr2),
    .ram_addr  (ram_addr2),
    .ram_din   (ram_din2),
    .rsp_valid (rsp_valid2)
  );

  assign bus.req_ready1 = ready1;
  assign bus.req_ready2 = ready2;
  assign bus.ram_wr1    = ram_wr1;
  assign bus.ram_wr2    = ram_wr2;
  assign bus.ram_addr1  = ram_addr1;
  assign bus.ram_addr2  = ram_addr2;
  assign bus.ram_din1   = ram_din1;
  assign bus.ram_din2   = ram_din2;
  assign bus.rsp_valid1 = rsp_valid1;
  assign bus.rsp_valid2 = rsp_valid2;
  assign bus.rsp_rdata1 = bus.ram_dout1;
  assign bus.rsp_rdata2 = bus.ram_dout2;

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// tb/tb_dpram_access_arbiter.sv - self-checking bench: RAM model, transaction-level scoreboard, directed vectors
module tb_dpram_access_arbiter;
  import dpram_pkg::*;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  dpram_access_arbiter_if #(.AW(4), .DW(8)) bus ();

`ifdef DPRAM_ARB_STATS_EN
  logic [7:0] conflict_cnt;
`endif

  dpram_access_arbiter #(.AW(4), .DW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef DPRAM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM with registered read data
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bus.ram_dout1 = 8'h00;
    bus.ram_dout2 = 8'h00;
  end
  always @(posedge clk) begin
    bus.ram_dout1 <= mem[bus.ram_addr1];
    bus.ram_dout2 <= mem[bus.ram_addr2];
    if (bus.ram_wr1) mem[bus.ram_addr1] <= bus.ram_din1;
    if (bus.ram_wr2) mem[bus.ram_addr2] <= bus.ram_din2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: contents in acceptance order, responses due two cycles later
  logic [7:0] mm [16];
  int         cyc = 0;
  int         due1[$], due2[$];
  logic [7:0] dat1[$], dat2[$];
  logic       e_wr1 = 0, e_wr2 = 0;
  logic [3:0] e_addr1 = 0, e_addr2 = 0;
  logic [7:0] e_din1 = 0, e_din2 = 0;
  logic       mpri = 0;
  int         mcnt = 0;
  logic       conf, x1, x2, acc1, acc2, er1, er2;

  initial for (int i = 0; i < 16; i++) mm[i] = 8'h00;

  always @(negedge clk) begin
    cyc++;
    conf = bus.req_valid1 && bus.req_valid2 && (bus.req_addr1 == bus.req_addr2) &&
           (bus.req_wr1 || bus.req_wr2);
    x1 = !rst && !(conf && mpri);
    x2 = !rst && !(conf && !mpri);
    chk("req_ready1", bus.req_ready1, x1);
    chk("req_ready2", bus.req_ready2, x2);
    chk("ram_wr1", bus.ram_wr1, e_wr1);
    chk("ram_wr2", bus.ram_wr2, e_wr2);
    chk("ram_addr1", bus.ram_addr1, e_addr1);
    chk("ram_addr2", bus.ram_addr2, e_addr2);
    chk("ram_din1", bus.ram_din1, e_din1);
    chk("ram_din2", bus.ram_din2, e_din2);
    er1 = (due1.size() > 0) && (due1[0] == cyc);
    er2 = (due2.size() > 0) && (due2[0] == cyc);
    chk("rsp_valid1", bus.rsp_valid1, er1);
    chk("rsp_valid2", bus.rsp_valid2, er2);
    if (er1) begin
      chk("rsp_rdata1", bus.rsp_rdata1, dat1[0]);
      void'(due1.pop_front());
      void'(dat1.pop_front());
    end
    if (er2) begin
      chk("rsp_rdata2", bus.rsp_rdata2, dat2[0]);
      void'(due2.pop_front());
      void'(dat2.pop_front());
    end
`ifdef DPRAM_ARB_STATS_EN
    chk("conflict_cnt", conflict_cnt, mcnt);
`endif
    if (rst) begin
      due1.delete(); dat1.delete(); due2.delete(); dat2.delete();
      e_wr1 = 0; e_wr2 = 0; e_addr1 = 0; e_addr2 = 0; e_din1 = 0; e_din2 = 0;
      mpri = 0; mcnt = 0;
    end else begin
      acc1 = bus.req_valid1 && x1;
      acc2 = bus.req_valid2 && x2;
      if (acc1 && bus.req_wr1) mm[bus.req_addr1] = bus.req_wdata1;
      if (acc2 && bus.req_wr2) mm[bus.req_addr2] = bus.req_wdata2;
      if (acc1 && !bus.req_wr1) begin due1.push_back(cyc + 2); dat1.push_back(mm[bus.req_addr1]); end
      if (acc2 && !bus.req_wr2) begin due2.push_back(cyc + 2); dat2.push_back(mm[bus.req_addr2]); end
      e_wr1 = acc1 && bus.req_wr1;
      e_wr2 = acc2 && bus.req_wr2;
      if (acc1) begin e_addr1 = bus.req_addr1; e_din1 = bus.req_wdata1; end
      if (acc2) begin e_addr2 = bus.req_addr2; e_din2 = bus.req_wdata2; end
      if (conf) begin
        mpri = !mpri;
        if (mcnt < 255) mcnt++;
      end
    end
  end

  task automatic drive(input logic v1, input req_t r1, input logic v2, input req_t r2);
    bus.req_valid1 = v1; bus.req_wr1 = r1.wr; bus.req_addr1 = r1.addr; bus.req_wdata1 = r1.wdata;
    bus.req_valid2 = v2; bus.req_wr2 = r2.wr; bus.req_addr2 = r2.addr; bus.req_wdata2 = r2.wdata;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, req_t'(0), 1'b0, req_t'(0));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, req_t'{1'b1, 4'd0, 8'hFF}, 1'b1, req_t'{1'b1, 4'd0, 8'hEE});
    repeat (3) step();
    chk("rst_ready1", bus.req_ready1, 1'b0);
    chk("rst_ram_wr1", bus.ram_wr1, 1'b0);
    chk("rst_ram_wr2", bus.ram_wr2, 1'b0);
    chk("rst_rsp_valid1", bus.rsp_valid1, 1'b0);
    rst = 1'b0;
    idle();
    chk("post_rst_ready1", bus.req_ready1, 1'b1);
    chk("post_rst_ready2", bus.req_ready2, 1'b1);

    // write then read on port 1
    drive(1'b1, req_t'{1'b1, 4'd3, 8'hA5}, 1'b0, req_t'(0));
    step();
    chk("wr_issue_ram_wr1", bus.ram_wr1, 1'b1);
    drive(1'b1, req_t'{1'b0, 4'd3, 8'h00}, 1'b0, req_t'(0));
    step();
    idle();
    step();
    chk("wr_rd_rsp_valid1", bus.rsp_valid1, 1'b1);
    chk("wr_rd_rdata1", bus.rsp_rdata1, 8'hA5);

    // write/write conflict from pri = 0
    drive(1'b1, req_t'{1'b1, 4'd7, 8'h11}, 1'b1, req_t'{1'b1, 4'd7, 8'h22});
    chk("ww_c1_ready1", bus.req_ready1, 1'b1);
    chk("ww_c1_ready2", bus.req_ready2, 1'b0);
    step();
    chk("ww_c2_ready1", bus.req_ready1, 1'b0);
    chk("ww_c2_ready2", bus.req_ready2, 1'b1);
    step();
    drive(1'b1, req_t'{1'b0, 4'd7, 8'h00}, 1'b0, req_t'(0));
    step();
    idle();
    step();
    chk("ww_final_rdata1", bus.rsp_rdata1, 8'h22);

    // read/read same address: no stall
    drive(1'b0, req_t'(0), 1'b1, req_t'{1'b1, 4'd5, 8'h5C});
    step();
    drive(1'b1, req_t'{1'b0, 4'd5, 8'h00}, 1'b1, req_t'{1'b0, 4'd5, 8'h00});
    chk("rr_ready1", bus.req_ready1, 1'b1);
    chk("rr_ready2", bus.req_ready2, 1'b1);
    step();
    idle();
    step();
    chk("rr_rsp_valid1", bus.rsp_valid1, 1'b1);
    chk("rr_rsp_valid2", bus.rsp_valid2, 1'b1);
    chk("rr_rdata1", bus.rsp_rdata1, 8'h5C);
    chk("rr_rdata2", bus.rsp_rdata2, 8'h5C);

    // pri still 0: port 1 write wins, port 2 read follows; pri becomes 1
    drive(1'b1, req_t'{1'b1, 4'd9, 8'h90}, 1'b1, req_t'{1'b0, 4'd9, 8'h00});
    chk("pri0_ready2", bus.req_ready2, 1'b0);
    step();
    drive(1'b0, req_t'(0), 1'b1, req_t'{1'b0, 4'd9, 8'h00});
    chk("pri0_hold_ready2", bus.req_ready2, 1'b1);
    step();
    idle();
    step();
    chk("pri0_rdata2", bus.rsp_rdata2, 8'h90);

    // read/write conflict with pri = 1: port 2 write wins
    drive(1'b1, req_t'{1'b0, 4'd9, 8'h00}, 1'b1, req_t'{1'b1, 4'd9, 8'hC3});
    chk("rw_ready1", bus.req_ready1, 1'b0);
    chk("rw_ready2", bus.req_ready2, 1'b1);
    step();
    drive(1'b1, req_t'{1'b0, 4'd9, 8'h00}, 1'b0, req_t'(0));
    chk("rw_hold_ready1", bus.req_ready1, 1'b1);
    step();
    idle();
    step();
    chk("rw_rsp_valid1", bus.rsp_valid1, 1'b1);
    chk("rw_rdata1", bus.rsp_rdata1, 8'hC3);

    // mixed traffic on a narrow address window, checked by the model
    for (int i = 0; i < 150; i++) begin
      drive(1'($urandom), req_t'{1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom)},
            1'($urandom), req_t'{1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom)});
      step();
    end
    idle();
    repeat (3) step();

    // reset drops an in-flight read
    drive(1'b1, req_t'{1'b0, 4'd3, 8'h00}, 1'b0, req_t'(0));
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_drop_rsp_valid1", bus.rsp_valid1, 1'b0);
    step();
    chk("rst_drop_rsp_valid1_late", bus.rsp_valid1, 1'b0);
    step();

`ifdef DPRAM_ARB_STATS_EN
    drive(1'b1, req_t'{1'b1, 4'd1, 8'h00}, 1'b1, req_t'{1'b1, 4'd1, 8'h00});
    repeat (300) step();
    chk("cnt_saturated", conflict_cnt, 8'd255);
    idle();
    rst = 1'b1;
    step();
    chk("cnt_cleared", conflict_cnt, 8'd0);
    rst = 1'b0;
    step();
`endif

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
